// File: rtl/tlb_op_unit.sv
// tlb_pkg / tlb_op_unit
//
// Executes the MIPS TLB instructions (TLBP, TLBR, TLBWI, TLBWR) issued by the
// pipeline against an external TLB array, and maintains the CP0 Random
// register used by TLBWR.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   op_valid/op_type     operation request (00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR)
//   op_ready/op_done     accept handshake (IDLE only) / one-cycle completion pulse
//   cp0_entryhi/index/wired/entry   current CP0 register values
//   tlbrw_index/we/wdata/rdata      TLB read/write port (rdata combinational)
//   tlbp_entry_hi/tlbp_index        TLB probe port (index bit 31 = miss)
//   wb_index_we/wb_index            Index register write-back
//   wb_entry_we/wb_entry            EntryHi/EntryLo0/EntryLo1/PageMask write-back
//   cp0_random                      Random register, zero-extended

package tlb_pkg;
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [11:0] pagemask;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;
endpackage

module tlb_op_unit
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRIES_NUM = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               op_valid,
    input  logic [1:0]                         op_type,
    output logic                               op_ready,
    output logic                               op_done,
    input  logic [31:0]                        cp0_entryhi,
    input  logic [31:0]                        cp0_index,
    input  logic [31:0]                        cp0_wired,
    input  tlb_entry_t                         cp0_entry,
    output logic [$clog2(TLB_ENTRIES_NUM)-1:0] tlbrw_index,
    output logic                               tlbrw_we,
    output tlb_entry_t                         tlbrw_wdata,
    input  tlb_entry_t                         tlbrw_rdata,
    output logic [31:0]                        tlbp_entry_hi,
    input  logic [31:0]                        tlbp_index,
    output logic                               wb_index_we,
    output logic [31:0]                        wb_index,
    output logic                               wb_entry_we,
    output tlb_entry_t                         wb_entry,
    output logic [31:0]                        cp0_random
);

    localparam int IW = $clog2(TLB_ENTRIES_NUM);
    localparam logic [IW-1:0] RAND_MAX = IW'(TLB_ENTRIES_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'b00,
        OP_TLBR  = 2'b01,
        OP_TLBWI = 2'b10,
        OP_TLBWR = 2'b11
    } op_e;

    state_e        r_state;
    state_e        w_state_next;
    op_e           r_op;
    logic [31:0]   r_entryhi;
    logic [IW-1:0] r_index;
    tlb_entry_t    r_entry;
    logic [IW-1:0] r_rand_lat;
    logic [31:0]   r_probe;
    tlb_entry_t    r_rdata;
    logic [IW-1:0] r_random;
    logic [31:0]   r_wired_q;
    logic [IW-1:0] w_random_next;
    logic          w_accept;
    logic          w_unused_index;

    // Only the low IW bits of Index select an entry.
    assign w_unused_index = ^cp0_index[31:IW];

    assign w_accept = (r_state == S_IDLE) && op_valid;

    // Random reloads on a Wired change, when Wired covers the whole TLB,
    // or once it reaches the wired boundary; otherwise it counts down.
    always_comb begin
        w_random_next = r_random - 1'b1;
        if ((cp0_wired != r_wired_q) || (|cp0_wired[31:IW]) ||
            (r_random <= cp0_wired[IW-1:0])) begin
            w_random_next = RAND_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= OP_TLBP;
            r_entryhi  <= '0;
            r_index    <= '0;
            r_entry    <= '0;
            r_rand_lat <= '0;
            r_probe    <= '0;
            r_rdata    <= '0;
            r_random   <= RAND_MAX;
            // Track Wired through reset so its first post-reset value is not
            // mistaken for a change.
            r_wired_q  <= cp0_wired;
        end else begin
            r_state   <= w_state_next;
            r_wired_q <= cp0_wired;
            r_random  <= w_random_next;
            if (w_accept) begin
                r_op       <= op_e'(op_type);
                r_entryhi  <= cp0_entryhi;
                r_index    <= cp0_index[IW-1:0];
                r_entry    <= cp0_entry;
                r_rand_lat <= r_random;
            end
            if (r_state == S_EXEC && r_op == OP_TLBP) r_probe <= tlbp_index;
            if (r_state == S_EXEC && r_op == OP_TLBR) r_rdata <= tlbrw_rdata;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        op_ready      = 1'b0;
        op_done       = 1'b0;
        tlbrw_index   = '0;
        tlbrw_we      = 1'b0;
        tlbrw_wdata   = '0;
        tlbp_entry_hi = '0;
        wb_index_we   = 1'b0;
        wb_entry_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) w_state_next = S_EXEC;
            end
            S_EXEC: begin
                w_state_next = S_RESP;
                case (r_op)
                    OP_TLBP:  tlbp_entry_hi = r_entryhi;
                    OP_TLBR:  tlbrw_index   = r_index;
                    OP_TLBWI: begin
                        tlbrw_we    = 1'b1;
                        tlbrw_index = r_index;
                        tlbrw_wdata = r_entry;
                    end
                    OP_TLBWR: begin
                        tlbrw_we    = 1'b1;
                        tlbrw_index = r_rand_lat;
                        tlbrw_wdata = r_entry;
                    end
                    default: ;
                endcase
            end
            S_RESP: begin
                w_state_next = S_IDLE;
                op_done      = 1'b1;
                wb_index_we  = (r_op == OP_TLBP);
                wb_entry_we  = (r_op == OP_TLBR);
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign wb_index   = r_probe;
    assign wb_entry   = r_rdata;
    assign cp0_random = {{(32 - IW){1'b0}}, r_random};

endmodule

// File: tb/tb_tlb_op_unit.sv
// tb_tlb_op_unit
//
// Directed bench for tlb_op_unit with a behavioural 16-entry TLB attached to
// the read/write and probe ports.

module tb_tlb_op_unit;
    import tlb_pkg::*;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op_type;
    logic        op_ready;
    logic        op_done;
    logic [31:0] cp0_entryhi;
    logic [31:0] cp0_index;
    logic [31:0] cp0_wired;
    tlb_entry_t  cp0_entry;
    logic [3:0]  tlbrw_index;
    logic        tlbrw_we;
    tlb_entry_t  tlbrw_wdata;
    tlb_entry_t  tlbrw_rdata;
    logic [31:0] tlbp_entry_hi;
    logic [31:0] tlbp_index;
    logic        wb_index_we;
    logic [31:0] wb_index;
    logic        wb_entry_we;
    tlb_entry_t  wb_entry;
    logic [31:0] cp0_random;

    int checks = 0;
    int passed = 0;

    tlb_entry_t e1, e2, e3;

    tlb_op_unit #(.TLB_ENTRIES_NUM(16)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_type(op_type),
        .op_ready(op_ready), .op_done(op_done),
        .cp0_entryhi(cp0_entryhi), .cp0_index(cp0_index),
        .cp0_wired(cp0_wired), .cp0_entry(cp0_entry),
        .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we),
        .tlbrw_wdata(tlbrw_wdata), .tlbrw_rdata(tlbrw_rdata),
        .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
        .wb_index_we(wb_index_we), .wb_index(wb_index),
        .wb_entry_we(wb_entry_we), .wb_entry(wb_entry),
        .cp0_random(cp0_random)
    );

    // Behavioural TLB: writable array, combinational read and VPN2 probe.
    tlb_entry_t  mem [16];
    logic [15:0] vld;

    always @(posedge clk) begin
        if (reset) vld <= '0;
        else if (tlbrw_we) begin
            mem[tlbrw_index] <= tlbrw_wdata;
            vld[tlbrw_index] <= 1'b1;
        end
    end

    assign tlbrw_rdata = mem[tlbrw_index];

    always_comb begin
        tlbp_index = 32'h8000_0000;
        for (int i = 0; i < 16; i++)
            if (vld[i] && mem[i].vpn2 == tlbp_entry_hi[31:13]) tlbp_index = 32'(i);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; returns in the EXEC cycle.
    task automatic issue(input logic [1:0] t);
        op_valid = 1'b1;
        op_type  = t;
        step();
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++; if (op_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", op_ready); else passed++;
        checks++; if (op_done !== 1'b0) $display("FAIL rst_done got %b want 0", op_done); else passed++;
        checks++; if (tlbrw_we !== 1'b0) $display("FAIL rst_we got %b want 0", tlbrw_we); else passed++;
        checks++; if ({wb_index_we, wb_entry_we} !== 2'b00) $display("FAIL rst_wb_we got %b want 00", {wb_index_we, wb_entry_we}); else passed++;
        checks++; if (wb_index !== 32'h0) $display("FAIL rst_wb_index got %h want 0", wb_index); else passed++;
        checks++; if (wb_entry !== '0) $display("FAIL rst_wb_entry got %h want 0", wb_entry); else passed++;
        checks++; if (cp0_random !== 32'd15) $display("FAIL rst_random got %0d want 15", cp0_random); else passed++;
        checks++; if ({tlbrw_index, tlbp_entry_hi} !== 36'h0) $display("FAIL rst_idx got %h/%h want 0", tlbrw_index, tlbp_entry_hi); else passed++;
        step();
        checks++; if (cp0_random !== 32'd14) $display("FAIL rst_random_dec got %0d want 14", cp0_random); else passed++;
    endtask

    task automatic test_reset_priority();
        cp0_index = 32'd1; cp0_entry = e1;
        op_valid = 1'b1; op_type = 2'b10; reset = 1'b1;
        step();
        reset = 1'b0; op_valid = 1'b0;
        checks++; if (op_ready !== 1'b1) $display("FAIL prio_ready got %b want 1", op_ready); else passed++;
        checks++; if (tlbrw_we !== 1'b0) $display("FAIL prio_we got %b want 0", tlbrw_we); else passed++;
        step();
        checks++; if ({op_done, tlbrw_we} !== 2'b00) $display("FAIL prio_done got %b want 00", {op_done, tlbrw_we}); else passed++;
    endtask

    task automatic test_tlbwi();
        cp0_index = 32'd5; cp0_entry = e1;
        checks++; if (op_ready !== 1'b1) $display("FAIL wi_ready got %b want 1", op_ready); else passed++;
        op_valid = 1'b1; op_type = 2'b10;
        step();
        // Held request with a different op must be ignored outside IDLE.
        op_type = 2'b00; cp0_index = 32'd7;
        checks++; if (op_ready !== 1'b0) $display("FAIL wi_exec_ready got %b want 0", op_ready); else passed++;
        checks++; if (tlbrw_we !== 1'b1) $display("FAIL wi_we got %b want 1", tlbrw_we); else passed++;
        checks++; if (tlbrw_index !== 4'd5) $display("FAIL wi_index got %0d want 5", tlbrw_index); else passed++;
        checks++; if (tlbrw_wdata !== e1) $display("FAIL wi_wdata got %h want %h", tlbrw_wdata, e1); else passed++;
        checks++; if (op_done !== 1'b0) $display("FAIL wi_exec_done got %b want 0", op_done); else passed++;
        step();
        op_valid = 1'b0;
        checks++; if (op_done !== 1'b1) $display("FAIL wi_done got %b want 1", op_done); else passed++;
        checks++; if ({tlbrw_we, wb_index_we, wb_entry_we} !== 3'b000) $display("FAIL wi_resp_we got %b want 000", {tlbrw_we, wb_index_we, wb_entry_we}); else passed++;
        checks++; if (tlbrw_index !== 4'd0) $display("FAIL wi_resp_index got %0d want 0", tlbrw_index); else passed++;
        step();
        checks++; if ({op_ready, op_done} !== 2'b10) $display("FAIL wi_idle got %b want 10", {op_ready, op_done}); else passed++;
    endtask

    task automatic test_tlbp();
        cp0_entryhi = {e1.vpn2, 5'b0, e1.asid};
        issue(2'b00);
        checks++; if (tlbp_entry_hi !== {e1.vpn2, 5'b0, e1.asid}) $display("FAIL p_key got %h want %h", tlbp_entry_hi, {e1.vpn2, 5'b0, e1.asid}); else passed++;
        checks++; if (tlbrw_we !== 1'b0) $display("FAIL p_we got %b want 0", tlbrw_we); else passed++;
        step();
        checks++; if ({op_done, wb_index_we, wb_entry_we} !== 3'b110) $display("FAIL p_resp got %b want 110", {op_done, wb_index_we, wb_entry_we}); else passed++;
        checks++; if (wb_index !== 32'h0000_0005) $display("FAIL p_hit got %h want 00000005", wb_index); else passed++;
        checks++; if (tlbp_entry_hi !== 32'h0) $display("FAIL p_key_hold got %h want 0", tlbp_entry_hi); else passed++;
        step();
        cp0_entryhi = {19'h0F0F0, 13'h0};
        issue(2'b00);
        step();
        checks++; if (wb_index_we !== 1'b1) $display("FAIL p_miss_we got %b want 1", wb_index_we); else passed++;
        checks++; if (wb_index !== 32'h8000_0000) $display("FAIL p_miss got %h want 80000000", wb_index); else passed++;
        step();
    endtask

    task automatic test_tlbr();
        cp0_index = 32'd3; cp0_entry = e2;
        issue(2'b10);
        step(); step();
        cp0_index = 32'h0000_0013; cp0_entry = e3;
        issue(2'b01);
        checks++; if (tlbrw_index !== 4'd3) $display("FAIL r_index got %0d want 3", tlbrw_index); else passed++;
        checks++; if (tlbrw_we !== 1'b0) $display("FAIL r_we got %b want 0", tlbrw_we); else passed++;
        step();
        checks++; if ({op_done, wb_entry_we, wb_index_we} !== 3'b110) $display("FAIL r_resp got %b want 110", {op_done, wb_entry_we, wb_index_we}); else passed++;
        checks++; if (wb_entry !== e2) $display("FAIL r_entry got %h want %h", wb_entry, e2); else passed++;
        step();
    endtask

    task automatic test_tlbwr();
        int n = 0;
        while (cp0_random !== 32'd9 && n < 40) begin
            step();
            n++;
        end
        checks++; if (cp0_random !== 32'd9) $display("FAIL wr_wait got %0d want 9", cp0_random); else passed++;
        cp0_entry = e3;
        issue(2'b11);
        checks++; if (cp0_random !== 32'd8) $display("FAIL wr_random got %0d want 8", cp0_random); else passed++;
        checks++; if (tlbrw_index !== 4'd9) $display("FAIL wr_index got %0d want 9", tlbrw_index); else passed++;
        checks++; if ({tlbrw_we, tlbrw_wdata} !== {1'b1, e3}) $display("FAIL wr_write got %b/%h want 1/%h", tlbrw_we, tlbrw_wdata, e3); else passed++;
        step();
        checks++; if ({op_done, tlbrw_we, wb_index_we, wb_entry_we} !== 4'b1000) $display("FAIL wr_resp got %b want 1000", {op_done, tlbrw_we, wb_index_we, wb_entry_we}); else passed++;
        step();
    endtask

    task automatic test_random();
        logic [31:0] exp;
        cp0_wired = 32'd4;
        step();
        exp = 32'd15;
        for (int i = 0; i < 30; i++) begin
            checks++; if (cp0_random !== exp) $display("FAIL rand_w4[%0d] got %0d want %0d", i, cp0_random, exp); else passed++;
            exp = (exp <= 32'd4) ? 32'd15 : exp - 32'd1;
            step();
        end
        cp0_wired = 32'd20;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (cp0_random !== 32'd15) $display("FAIL rand_w20[%0d] got %0d want 15", i, cp0_random); else passed++;
        end
        cp0_wired = 32'd2;
        step();
        checks++; if (cp0_random !== 32'd15) $display("FAIL rand_w2 got %0d want 15", cp0_random); else passed++;
        for (int i = 0; i < 5; i++) step();
        checks++; if (cp0_random !== 32'd10) $display("FAIL rand_w2_dec got %0d want 10", cp0_random); else passed++;
        cp0_wired = 32'd3;
        step();
        checks++; if (cp0_random !== 32'd15) $display("FAIL rand_wchg got %0d want 15", cp0_random); else passed++;
    endtask

    task automatic test_abort();
        cp0_index = 32'd6; cp0_entry = e1;
        issue(2'b10);
        checks++; if (tlbrw_we !== 1'b1) $display("FAIL ab_exec_we got %b want 1", tlbrw_we); else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (tlbrw_we !== 1'b0) $display("FAIL ab_we got %b want 0", tlbrw_we); else passed++;
        checks++; if ({op_ready, op_done} !== 2'b10) $display("FAIL ab_ready got %b want 10", {op_ready, op_done}); else passed++;
        checks++; if (cp0_random !== 32'd15) $display("FAIL ab_random got %0d want 15", cp0_random); else passed++;
        step();
        checks++; if ({op_done, tlbrw_we, wb_index_we, wb_entry_we} !== 4'b0000) $display("FAIL ab_after got %b want 0000", {op_done, tlbrw_we, wb_index_we, wb_entry_we}); else passed++;
        cp0_entryhi = {e1.vpn2, 13'h0};
        issue(2'b00);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({op_done, wb_index_we} !== 2'b00) $display("FAIL ab_resp got %b want 00", {op_done, wb_index_we}); else passed++;
        checks++; if (wb_index !== 32'h0) $display("FAIL ab_wb_index got %h want 0", wb_index); else passed++;
    endtask

    initial begin
        e1 = '{vpn2: 19'h5A5A5, asid: 8'h11, pagemask: 12'h000, g: 1'b0,
               pfn0: 20'hABCDE, c0: 3'd3, d0: 1'b1, v0: 1'b1,
               pfn1: 20'h12345, c1: 3'd2, d1: 1'b0, v1: 1'b1};
        e2 = '{vpn2: 19'h3C3C3, asid: 8'h22, pagemask: 12'h003, g: 1'b1,
               pfn0: 20'h00F00, c0: 3'd5, d0: 1'b0, v0: 1'b1,
               pfn1: 20'hF00F0, c1: 3'd3, d1: 1'b1, v1: 1'b0};
        e3 = '{vpn2: 19'h01234, asid: 8'h33, pagemask: 12'hFFF, g: 1'b0,
               pfn0: 20'h55555, c0: 3'd1, d0: 1'b1, v0: 1'b0,
               pfn1: 20'hAAAAA, c1: 3'd7, d1: 1'b1, v1: 1'b1};
        reset = 1'b1; op_valid = 1'b0; op_type = 2'b00;
        cp0_entryhi = '0; cp0_index = '0; cp0_wired = '0; cp0_entry = '0;
        test_reset();
        test_reset_priority();
        test_tlbwi();
        test_tlbp();
        test_tlbr();
        test_tlbwr();
        test_random();
        test_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tlb_op_unit.md
TLB_OP_UNIT -- requirements
Module: tlb_op_unit

Interface
REQ-001 SHALL have parameter TLB_ENTRIES_NUM, default 16, number of TLB entries (power of two); IW = $clog2(TLB_ENTRIES_NUM).
REQ-002 SHALL have clk  input  1  clock.
REQ-003 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have op_valid  input  1  TLB instruction request from the pipeline.
REQ-005 SHALL have op_type  input  2  operation: 00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR.
REQ-006 SHALL have op_ready  output  1  unit can accept an operation.
REQ-007 SHALL have op_done  output  1  one-cycle completion pulse.
REQ-008 SHALL have cp0_entryhi, cp0_index, cp0_wired  input  32 each  current CP0 register values.
REQ-009 SHALL have cp0_entry  input  tlb_entry_t  entry assembled from EntryHi/EntryLo0/EntryLo1/PageMask.
REQ-010 SHALL have tlbrw_index  output  IW  entry index to TLB; tlbrw_we  output  1  TLB write enable; tlbrw_wdata  output  tlb_entry_t  write data.
REQ-011 SHALL have tlbrw_rdata  input  tlb_entry_t  TLB read data (combinational from tlbrw_index).
REQ-012 SHALL have tlbp_entry_hi  output  32  probe key; tlbp_index  input  32  probe result (bit 31 = miss, low IW bits = hit index).
REQ-013 SHALL have wb_index_we  output  1, wb_index  output  32  Index write-back.
REQ-014 SHALL have wb_entry_we  output  1, wb_entry  output  tlb_entry_t  EntryHi/EntryLo0/EntryLo1/PageMask write-back.
REQ-015 SHALL have cp0_random  output  32  Random register value.

Function
REQ-016 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; op_ready = 1 only in IDLE.
REQ-017 SHALL accept an operation on a clk edge in IDLE with op_valid=1, latching op_type, cp0_entryhi, cp0_index[IW-1:0], cp0_entry and current random value; inputs are ignored outside IDLE.
REQ-018 SHALL spend exactly one cycle in EXEC and one in RESP; op_done = 1 only in RESP, i.e. the second cycle after acceptance.
REQ-019 TLBP: in EXEC SHALL drive tlbp_entry_hi = latched entryhi and register tlbp_index at end of EXEC; in RESP SHALL assert wb_index_we with wb_index = registered value.
REQ-020 TLBR: in EXEC SHALL drive tlbrw_index = latched index and register tlbrw_rdata; in RESP SHALL assert wb_entry_we with wb_entry = registered entry.
REQ-021 TLBWI: in EXEC SHALL assert tlbrw_we for exactly one cycle with tlbrw_index = latched index, tlbrw_wdata = latched entry; no write-back in RESP.
REQ-022 TLBWR: identical to TLBWI except tlbrw_index = random value latched at acceptance.
REQ-023 tlbrw_we, wb_index_we, wb_entry_we SHALL be 0 in every cycle not stated above; tlbp_entry_hi and tlbrw_index SHALL hold 0 outside EXEC.
REQ-024 Random SHALL decrement by 1 every cycle; when value <= wired[IW-1:0] it SHALL load TLB_ENTRIES_NUM-1 next cycle instead.
REQ-025 If cp0_wired >= TLB_ENTRIES_NUM, random SHALL stay at TLB_ENTRIES_NUM-1.
REQ-026 cp0_random SHALL be zero-extended random value; out-of-range cp0_index SHALL use only its low IW bits.
REQ-027 A change of cp0_wired SHALL force random to TLB_ENTRIES_NUM-1 next cycle, overriding decrement.

Reset
REQ-028 On reset: state IDLE, op_ready=1 in the first post-reset cycle, op_done=0, all write enables 0, all write-back data 0, random = TLB_ENTRIES_NUM-1.
REQ-029 Reset during EXEC or RESP SHALL abort the operation: no tlbrw_we, no write-back, no op_done in the following cycle.
REQ-030 Reset SHALL have priority over acceptance in the same cycle.

Verification
REQ-031 TLBWI, cp0_index=5, entry E -> tlbrw_we=1 one cycle with index 5, data E; op_done 2 cycles after accept; no wb.
REQ-032 TLBP for entryhi matching entry 5 -> wb_index_we=1, wb_index=0x00000005; non-matching -> wb_index=0x80000000.
REQ-033 TLBR index 3 after writing E to 3 -> wb_entry_we=1, wb_entry=E in RESP cycle.
REQ-034 wired=4, N=16, run 30 cycles -> random sequence 15,14,...,4,15,...; never <4; wired=20 -> random constant 15.
REQ-035 TLBWR accepted while random=9 -> tlbrw_index=9 in EXEC although random has already decremented.
REQ-036 Reset asserted in EXEC of TLBWI -> tlbrw_we stays 0 after reset, op_ready=1, random=15.
